vmem_write_arbiter: RTL and testbench

Write-side controller for the 8192x24 video memory behind the VGA display block. It shares the single memory write port (address, data, write enable) between a host write port and a built-in rectangle-fill engine, using round-robin arbitration. The fill engine clears or paints rectangular regions of the 8x8-pixel cell grid without host involvement. The block sits entirely in the write-clock domain and drives the memory's port-B signals directly.

---
 rtl/vmem_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vmem_write_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_write_arbiter.sv
// Video memory write-port controller: round-robin between host
// writes and a rectangle-fill engine over the 8x8 cell grid.
module vmem_write_arbiter #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic        clkb,
  input  logic        rst_n,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [12:0] host_addr,
  input  logic [23:0] host_data,
  input  logic        fill_start,
  input  logic [6:0]  fill_x0,
  input  logic [6:0]  fill_x1,
  input  logic [5:0]  fill_y0,
  input  logic [5:0]  fill_y1,
  input  logic [23:0] fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic [12:0] mem_waddr,
  output logic [23:0] mem_wdata,
  output logic        mem_web
);

  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [5:0] YMAX = 6'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  cx_q, cx_d;
  logic [5:0]  cy_q, cy_d;
  logic [6:0]  x0_q, x0_d;
  logic [6:0]  x1_q, x1_d;
  logic [5:0]  y0_q, y0_d;
  logic [5:0]  y1_q, y1_d;
  logic [23:0] color_q, color_d;
  logic        last_fill_q, last_fill_d;
  logic        mem_web_q, mem_web_d;
  logic [12:0] mem_waddr_q, mem_waddr_d;
  logic [23:0] mem_wdata_q, mem_wdata_d;

  logic        fill_req;
  logic        host_gnt;
  logic        fill_gnt;
  logic [6:0]  x1_clip;
  logic [5:0]  y1_clip;
  logic        empty;

  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    color_d     = color_q;
    last_fill_d = last_fill_q;
    mem_web_d   = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;

    // Host wins unless the fill is waiting and the host went last.
    fill_req = (state_q == RUN);
    host_gnt = host_valid & (~fill_req | last_fill_q);
    fill_gnt = fill_req & ~host_gnt;

    x1_clip = (fill_x1 > XMAX) ? XMAX : fill_x1;
    y1_clip = (fill_y1 > YMAX) ? YMAX : fill_y1;
    empty   = (fill_x0 > x1_clip) | (fill_y0 > y1_clip)
            | (fill_x0 > XMAX) | (fill_y0 > YMAX);

    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          x0_d    = fill_x0;
          x1_d    = x1_clip;
          y0_d    = fill_y0;
          y1_d    = y1_clip;
          color_d = fill_color;
          if (empty) begin
            state_d = DONE;
          end else begin
            cx_d    = fill_x0;
            cy_d    = fill_y0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (fill_gnt) begin
          if (cx_q != x1_q) begin
            cx_d = cx_q + 7'd1;
          end else if (cy_q != y1_q) begin
            cx_d = x0_q;
            cy_d = cy_q + 6'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (1'b1)
      host_gnt: begin
        mem_web_d   = 1'b1;
        mem_waddr_d = host_addr;
        mem_wdata_d = host_data;
        last_fill_d = 1'b0;
      end
      fill_gnt: begin
        mem_web_d   = 1'b1;
        mem_waddr_d = {cy_q, cx_q};
        mem_wdata_d = color_q;
        last_fill_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      last_fill_q <= 1'b1;
      mem_web_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      last_fill_q <= last_fill_d;
      mem_web_q   <= mem_web_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign host_ready = host_gnt;
  assign fill_busy  = (state_q != IDLE);
  assign fill_done  = (state_q == DONE);
  assign mem_web    = mem_web_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vmem_write_arbiter.sv
// Bench for vmem_write_arbiter: directed plan plus random traffic,
// checked every cycle against a cell-list reference model.
module tb_vmem_write_arbiter;

  logic        clkb;
  logic        rst_n;
  logic        host_valid;
  logic        host_ready;
  logic [12:0] host_addr;
  logic [23:0] host_data;
  logic        fill_start;
  logic [6:0]  fill_x0;
  logic [6:0]  fill_x1;
  logic [5:0]  fill_y0;
  logic [5:0]  fill_y1;
  logic [23:0] fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic [12:0] mem_waddr;
  logic [23:0] mem_wdata;
  logic        mem_web;

  vmem_write_arbiter dut (
    .clkb       (clkb),
    .rst_n      (rst_n),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .fill_start (fill_start),
    .fill_x0    (fill_x0),
    .fill_x1    (fill_x1),
    .fill_y0    (fill_y0),
    .fill_y1    (fill_y1),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_web    (mem_web)
  );

  initial clkb = 1'b0;
  always #5 clkb = ~clkb;

  int n_err;
  int n_checks;

  // reference model: phase 0 idle, 1 filling, 2 done pulse
  int          m_phase;
  int          m_cells[$];
  logic [23:0] m_color;
  bit          m_last_fill;
  logic        e_web;
  logic [12:0] e_addr;
  logic [23:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase     = 0;
    m_cells.delete();
    m_color     = '0;
    m_last_fill = 1'b1;
    e_web       = 1'b0;
    e_addr      = '0;
    e_data      = '0;
  endtask

  task automatic model_step();
    bit frun, hg, fg;
    int xe, ye;
    frun = (m_phase == 1);
    hg   = host_valid && (!frun || m_last_fill);
    fg   = frun && !hg;
    if (hg) begin
      e_web = 1'b1;
      e_addr = host_addr;
      e_data = host_data;
      m_last_fill = 1'b0;
    end else if (fg) begin
      e_web = 1'b1;
      e_addr = 13'(m_cells.pop_front());
      e_data = m_color;
      m_last_fill = 1'b1;
    end else begin
      e_web = 1'b0;
    end
    case (m_phase)
      0: if (fill_start) begin
        xe = (int'(fill_x1) > 79) ? 79 : int'(fill_x1);
        ye = (int'(fill_y1) > 59) ? 59 : int'(fill_y1);
        m_color = fill_color;
        for (int y = int'(fill_y0); y <= ye; y++)
          for (int x = int'(fill_x0); x <= xe; x++)
            m_cells.push_back(y * 128 + x);
        m_phase = (m_cells.size() == 0) ? 2 : 1;
      end
      1: if (fg && m_cells.size() == 0) m_phase = 2;
      default: m_phase = 0;
    endcase
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic tick();
    if (!rst_n) model_reset();
    #1;
    chk("host_ready", 32'(host_ready),
        32'(host_valid && (m_phase != 1 || m_last_fill)));
    chk("fill_busy", 32'(fill_busy), 32'(m_phase != 0));
    chk("fill_done", 32'(fill_done), 32'(m_phase == 2));
    chk("mem_web", 32'(mem_web), 32'(e_web));
    chk("mem_waddr", 32'(mem_waddr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_data));
    if (rst_n) model_step();
    @(negedge clkb);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_fill(input int x0, input int x1, input int y0,
                            input int y1, input logic [23:0] c);
    fill_x0    = 7'(x0);
    fill_x1    = 7'(x1);
    fill_y0    = 6'(y0);
    fill_y1    = 6'(y1);
    fill_color = c;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    rst_n = 1'b0;
    host_valid = 1'b0;
    host_addr = '0;
    host_data = '0;
    fill_start = 1'b0;
    fill_x0 = '0;
    fill_x1 = '0;
    fill_y0 = '0;
    fill_y1 = '0;
    fill_color = '0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    run(2);

    host_valid = 1'b1;
    host_addr  = 13'h0A5;
    host_data  = 24'h123456;
    tick();
    host_valid = 1'b0;
    run(2);

    start_fill(3, 4, 1, 2, 24'hFF0000);
    run(6);

    host_valid = 1'b1;
    host_addr  = 13'h1FFF;
    host_data  = 24'hABCDEF;
    start_fill(0, 3, 0, 0, 24'h00FF00);
    run(9);
    host_valid = 1'b0;
    run(2);

    start_fill(78, 100, 59, 59, 24'h0000FF);
    run(4);
    start_fill(5, 2, 0, 0, 24'h111111);
    run(3);

    start_fill(0, 2, 0, 1, 24'h222222);
    run(2);
    fill_x0 = 7'd10;
    fill_x1 = 7'd12;
    fill_y0 = 6'd5;
    fill_y1 = 6'd6;
    fill_color = 24'h333333;
    fill_start = 1'b1;
    run(2);
    fill_start = 1'b0;
    run(6);

    start_fill(0, 3, 0, 3, 24'h444444);
    run(3);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(3);
    host_valid = 1'b1;
    host_addr  = 13'h0123;
    host_data  = 24'h765432;
    tick();
    host_valid = 1'b0;
    run(2);

    for (int i = 0; i < 2000; i++) begin
      host_valid = 1'($urandom_range(0, 1));
      host_addr  = 13'($urandom);
      host_data  = 24'($urandom);
      fill_start = ($urandom_range(0, 7) == 0);
      fill_x0    = 7'($urandom_range(0, 127));
      fill_x1    = 7'(int'(fill_x0) + $urandom_range(0, 4));
      fill_y0    = 6'($urandom_range(0, 63));
      fill_y1    = 6'(int'(fill_y0) + $urandom_range(0, 3));
      fill_color = 24'($urandom);
      tick();
    end
    host_valid = 1'b0;
    fill_start = 1'b0;
    run(60);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
